// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard controller for a five-stage in-order core. It resolves
// three kinds of hazard seen between the ID and EX stages:
//   * control redirect (taken branch / resolved jump in EX): squash the two
//     younger instructions in IF/ID and ID/EX;
//   * load-use: the ID instruction reads a register that the load in EX has
//     not produced yet; insert one bubble into ID/EX and freeze the front end;
//   * multi-cycle multiply/divide (only when HAZARD_MDU_EN is defined): freeze
//     the whole front of the pipe for MDU_CYCLES cycles while the MDU works.
// A free-running saturating counter reports how many cycles the PC was held.
//
// Build option:
//   HAZARD_MDU_EN  defined   -> IDLE/BUSY sequencer with 6-bit down-counter.
//                  undefined -> ex_mdu_start is ignored; id_ex_hold,
//                               ex_mem_flush and mdu_done are tied low.
//
// Parameters:
//   MDU_CYCLES   total stall cycles for one MDU operation (2..63)
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   id_rs1, id_rs2     source register indices of the instruction in ID
//   id_uses_rs1/rs2    the ID instruction really reads rs1 / rs2
//   ex_rd              destination register of the instruction in EX
//   ex_writeReg        EX instruction writes the register file
//   ex_memOut          EX instruction is a load
//   ex_redirect        branch taken / jump resolved in EX
//   ex_mdu_start       EX instruction starts a multi-cycle MDU operation
//   pc_hold            freeze the PC
//   if_id_hold         freeze IF/ID
//   if_id_flush        clear IF/ID to a bubble
//   id_ex_hold         freeze ID/EX
//   id_ex_flush        load a bubble into ID/EX
//   ex_mem_flush       load a bubble into EX/MEM
//   mdu_done           one-cycle pulse on the final MDU stall cycle
//   stall_cycles       saturating count of cycles with pc_hold=1
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int MDU_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_writeReg,
  input  logic        ex_memOut,
  input  logic        ex_redirect,
  input  logic        ex_mdu_start,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_hold,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mdu_done,
  output logic [31:0] stall_cycles
);

  // Load-use detection. x0 is hard-wired to zero, so a load targeting it can
  // never create a dependency.
  logic rs1_hit;
  logic rs2_hit;
  logic lu;

  always_comb begin
    rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    lu      = ex_writeReg && ex_memOut && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  end

  // MDU sequencer view used by the output decode:
  //   busy      - currently inside a multi-cycle stall (after the start cycle)
  //   mdu_go    - an MDU operation is being accepted this cycle
  //   last_busy - this is the final stall cycle
  logic busy;
  logic mdu_go;
  logic last_busy;

`ifdef HAZARD_MDU_EN
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state;
  logic [5:0] cnt;

  // The start cycle itself is the first stall cycle, and the cnt==0 cycle is
  // the last, so loading MDU_CYCLES-2 yields MDU_CYCLES held cycles in total.
  localparam logic [5:0] CNT_LOAD = 6'(MDU_CYCLES - 2);

  // A redirect in the same cycle as a start wins: the MDU instruction is on
  // the squashed path (or the combination is illegal), so BUSY is not entered.
  always_comb begin
    busy      = (state == BUSY);
    mdu_go    = (state == IDLE) && !ex_redirect && ex_mdu_start;
    last_busy = busy && (cnt == 6'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu_go) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt == 6'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 6'd0;
        end
      endcase
    end
  end
`else
  // Without the MDU the start request has no meaning and is dropped.
  logic mdu_start_unused;

  always_comb begin
    mdu_start_unused = ex_mdu_start;
    busy             = 1'b0;
    mdu_go           = 1'b0;
    last_busy        = 1'b0;
  end
`endif

  // Output decode. Priority: reset, MDU busy, redirect, MDU start, load-use.
  // Reset gates the outputs combinationally so they drop the moment rst rises.
  always_comb begin
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mdu_done     = 1'b0;
    if (!rst) begin
      if (busy) begin
        pc_hold      = 1'b1;
        if_id_hold   = 1'b1;
        id_ex_hold   = 1'b1;
        ex_mem_flush = 1'b1;
        mdu_done     = last_busy;
      end else if (ex_redirect) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (mdu_go) begin
        // The MDU instruction stays in EX; ID/EX is frozen rather than
        // bubbled even when a load-use is also present.
        pc_hold      = 1'b1;
        if_id_hold   = 1'b1;
        id_ex_hold   = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (lu) begin
        pc_hold      = 1'b1;
        if_id_hold   = 1'b1;
        id_ex_flush  = 1'b1;
      end
    end
  end

  // Stall statistics: counts held-PC cycles and sticks at all-ones.
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (pc_hold && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int MC = 4;
`ifdef HAZARD_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        id_uses_rs1 = 1'b0;
  logic        id_uses_rs2 = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_writeReg = 1'b0;
  logic        ex_memOut = 1'b0;
  logic        ex_redirect = 1'b0;
  logic        ex_mdu_start = 1'b0;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
  logic        ex_mem_flush, mdu_done;
  logic [31:0] stall_cycles;

  hazard_unit #(.MDU_CYCLES(MC)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_writeReg(ex_writeReg), .ex_memOut(ex_memOut),
    .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mdu_done(mdu_done),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: remaining stall cycles of an MDU operation (0 = none)
  // and the expected statistics counter.
  int          stall_left = 0;
  logic [31:0] m_sc = '0;
  logic e_pc, e_ifh, e_iff, e_idh, e_idf, e_emf, e_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_outputs();
    logic dep;
    {e_pc, e_ifh, e_iff, e_idh, e_idf, e_emf, e_done} = '0;
    if (rst) begin
      stall_left = 0;
      m_sc = '0;
      return;
    end
    dep = ex_writeReg && ex_memOut && ex_rd != 0 &&
          ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (stall_left > 0) begin
      {e_pc, e_ifh, e_idh, e_emf} = 4'b1111;
      e_done = (stall_left == 1);
    end else if (ex_redirect) begin
      {e_iff, e_idf} = 2'b11;
    end else if (MDU_EN && ex_mdu_start) begin
      {e_pc, e_ifh, e_idh, e_emf} = 4'b1111;
    end else if (dep) begin
      {e_pc, e_ifh, e_idf} = 3'b111;
    end
  endtask

  task automatic model_clock();
    if (rst) begin
      stall_left = 0;
      m_sc = '0;
      return;
    end
    if (e_pc && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    if (stall_left > 0) stall_left--;
    else if (MDU_EN && !ex_redirect && ex_mdu_start) stall_left = MC - 1;
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then
  // check the counter after the following posedge.
  task automatic step(input string tag, input logic r,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic wr, input logic mem, input logic redir,
                      input logic start);
    @(negedge clk);
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_writeReg = wr; ex_memOut = mem;
    ex_redirect = redir; ex_mdu_start = start;
    #1;
    model_outputs();
    chk({tag, ".pc_hold"},      32'(pc_hold),      32'(e_pc));
    chk({tag, ".if_id_hold"},   32'(if_id_hold),   32'(e_ifh));
    chk({tag, ".if_id_flush"},  32'(if_id_flush),  32'(e_iff));
    chk({tag, ".id_ex_hold"},   32'(id_ex_hold),   32'(e_idh));
    chk({tag, ".id_ex_flush"},  32'(id_ex_flush),  32'(e_idf));
    chk({tag, ".ex_mem_flush"}, 32'(ex_mem_flush), 32'(e_emf));
    chk({tag, ".mdu_done"},     32'(mdu_done),     32'(e_done));
    chk({tag, ".stall_now"},    stall_cycles,      m_sc);
    @(posedge clk);
    model_clock();
    #1;
    chk({tag, ".stall_next"},   stall_cycles,      m_sc);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    step("reset", 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    step("reset2", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("idle0");

    // Load-use on rs1: one bubble, counter 0 -> 1
    step("lu_rs1", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu_count_is_1", stall_cycles, 32'd1);
    idle("lu_after");
    // Load-use via rs2 only
    step("lu_rs2", 1'b0, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    // Match but rs1 not actually used, and non-load writer
    step("lu_unused", 1'b0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    step("lu_noload", 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    // x0 filter
    step("x0", 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    // Redirect beats load-use
    step("redir_lu", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    idle("idle1");

    // MDU operation with redirect in cycle 2
    step("mdu_c1", 1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    step("mdu_c2", 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    step("mdu_c3", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("mdu_c4");
    idle("mdu_c5");
    // Illegal redirect + start: redirect response, no BUSY
    step("illegal", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("illegal_after");

    // Reset in cycle 2 of an MDU stall
    step("rbusy_c1", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("rbusy_c2", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rbusy_count", stall_cycles, 32'd0);
    idle("rbusy_c3");
    idle("rbusy_c4");

    // Saturation of the stall counter
    dut.stall_cnt = 32'hFFFF_FFFE;
    m_sc = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++)
      step("sat", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);
    step("sat_rst", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 63) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
    end
    idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MDU_CYCLES, default 32, range 2..63: total stall cycles for one multi-cycle MDU operation.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads rs1 / rs2.
REQ-006 ex_rd  in  5  destination register of the instruction in EX.
REQ-007 ex_writeReg  in  1  the EX instruction writes the register file.
REQ-008 ex_memOut  in  1  the EX instruction is a load; its result comes from memory.
REQ-009 ex_redirect  in  1  branch taken or jump resolved in EX.
REQ-010 ex_mdu_start  in  1  the EX instruction is a multi-cycle multiply/divide; sampled only in IDLE.
REQ-011 pc_hold  out  1  freeze the PC.
REQ-012 if_id_hold  out  1  freeze IF/ID.
REQ-013 if_id_flush  out  1  clear IF/ID to a bubble.
REQ-014 id_ex_hold  out  1  freeze ID/EX contents.
REQ-015 id_ex_flush  out  1  load a bubble into ID/EX (pause/flush of ID/EX).
REQ-016 ex_mem_flush  out  1  load a bubble into EX/MEM.
REQ-017 mdu_done  out  1  one-cycle pulse on the final MDU stall cycle.
REQ-018 stall_cycles  out  32  saturating count of cycles with pc_hold=1.

Function
REQ-019 States: IDLE, BUSY; 6-bit down-counter cnt; all outputs except stall_cycles are combinational from state, cnt and inputs.
REQ-020 Load-use condition LU = ex_writeReg & ex_memOut & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-021 IDLE, ex_redirect=1: if_id_flush=1, id_ex_flush=1, all holds 0; LU and ex_mdu_start ignored; remain IDLE.
REQ-022 IDLE, no redirect, ex_mdu_start=1: pc_hold=if_id_hold=id_ex_hold=ex_mem_flush=1, id_ex_flush=0 even if LU; cnt <= MDU_CYCLES-2; next BUSY.
REQ-023 IDLE, no redirect, no start, LU=1: pc_hold=if_id_hold=id_ex_flush=1 for exactly that cycle (one bubble); remain IDLE.
REQ-024 IDLE, none of the above: all control outputs 0.
REQ-025 BUSY: pc_hold=if_id_hold=id_ex_hold=ex_mem_flush=1; ex_redirect, ex_mdu_start and LU ignored; flushes of IF/ID and ID/EX are 0.
REQ-026 BUSY with cnt==0: mdu_done=1, next IDLE; otherwise cnt <= cnt-1.
REQ-027 Holds are therefore asserted for exactly MDU_CYCLES consecutive cycles, starting with the cycle in which ex_mdu_start is sampled in IDLE.
REQ-028 stall_cycles increments by 1 on every posedge with pc_hold=1; it holds at 32'hFFFFFFFF with no wrap.
REQ-029 ex_redirect and ex_mdu_start asserted together is illegal; the required response is REQ-021, and BUSY is not entered.

Reset
REQ-030 rst=1 immediately forces state=IDLE, cnt=0, stall_cycles=0, and every control output plus mdu_done to 0, regardless of inputs.
REQ-031 rst asserted mid-BUSY aborts the stall with no mdu_done pulse; the first cycle after release behaves as IDLE.

Configuration
REQ-032 Macro HAZARD_MDU_EN defined: REQ-022, REQ-025 and REQ-026 are implemented as specified.
REQ-033 HAZARD_MDU_EN undefined: ex_mdu_start is ignored; BUSY and cnt do not exist; id_ex_hold, ex_mem_flush and mdu_done are tied 0; all other behaviour is unchanged.

Verification
REQ-034 Load-use: ex_memOut=1, ex_writeReg=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> pc_hold, if_id_hold and id_ex_flush are 1 for 1 cycle; stall_cycles goes 0->1.
REQ-035 x0 filter: same as REQ-034 but ex_rd=0 and id_rs1=0 -> all outputs 0.
REQ-036 Redirect beats load-use: LU true and ex_redirect=1 -> if_id_flush=id_ex_flush=1, pc_hold=0, stall_cycles unchanged.
REQ-037 MDU (HAZARD_MDU_EN, MDU_CYCLES=4): ex_mdu_start pulse -> holds high for 4 cycles; mdu_done only in cycle 4; ex_redirect=1 in cycle 2 has no effect; IDLE in cycle 5.
REQ-038 Reset mid-BUSY: rst in cycle 2 of a 32-cycle stall -> outputs 0 at once, no mdu_done, stall_cycles=0.
REQ-039 Saturation: preload stall_cycles=32'hFFFFFFFE, apply 3 load-use cycles -> counter reaches 32'hFFFFFFFF and holds there.
